// File: rtl/hazard_scoreboard_if.sv
// Issue/decode bundle between the pipeline and hazard_scoreboard.
// HAZARD_SCOREBOARD_PERF_EN adds the stall_cycles performance counter to the bundle.
interface hazard_scoreboard_if #(
    parameter int NREG = 32,
    parameter int REGW = $clog2(NREG),
    parameter int CNTW = 4
);
    logic            issue_valid;
    logic            issue_we;
    logic [REGW-1:0] issue_rd;
    logic [CNTW-1:0] issue_lat;
    logic            hold;
    logic            flush;
    logic [REGW-1:0] rsD;
    logic [REGW-1:0] rtD;
    logic            useRsD;
    logic            useRtD;
    logic            stallD;
    logic [NREG-1:0] busy_vec;
`ifdef HAZARD_SCOREBOARD_PERF_EN
    logic [31:0]     stall_cycles;

    modport master (
        output issue_valid, issue_we, issue_rd, issue_lat, hold, flush,
        output rsD, rtD, useRsD, useRtD,
        input  stallD, busy_vec, stall_cycles
    );
    modport slave (
        input  issue_valid, issue_we, issue_rd, issue_lat, hold, flush,
        input  rsD, rtD, useRsD, useRtD,
        output stallD, busy_vec, stall_cycles
    );
`else
    modport master (
        output issue_valid, issue_we, issue_rd, issue_lat, hold, flush,
        output rsD, rtD, useRsD, useRtD,
        input  stallD, busy_vec
    );
    modport slave (
        input  issue_valid, issue_we, issue_rd, issue_lat, hold, flush,
        input  rsD, rtD, useRsD, useRtD,
        output stallD, busy_vec
    );
`endif
endinterface

// File: rtl/hazard_scoreboard.sv
// Per-register latency scoreboard for the decode stage: stalls decode while a source is pending.
// Define HAZARD_SCOREBOARD_PERF_EN to add the stall_cycles performance counter.
module hazard_scoreboard #(
    parameter int NREG   = 32,
    parameter int REGW   = $clog2(NREG),
    parameter int MAXLAT = 8,
    parameter int CNTW   = $clog2(MAXLAT + 1)
) (
    input  logic               clk,
    input  logic               resetn,
    hazard_scoreboard_if.slave sb
);
    localparam logic [CNTW-1:0] ZeroCnt = {CNTW{1'b0}};
    localparam logic [CNTW-1:0] OneCnt  = {{(CNTW-1){1'b0}}, 1'b1};
    localparam logic [CNTW-1:0] MaxLatC = CNTW'(MAXLAT);
    localparam logic [REGW-1:0] ZeroReg = {REGW{1'b0}};

    function automatic logic [CNTW-1:0] satLat(input logic [CNTW-1:0] lat);
        return (lat > MaxLatC) ? MaxLatC : lat;
    endfunction

    logic [CNTW-1:0] cnt_r      [NREG];
    logic [CNTW-1:0] cntNext_s  [NREG];
    logic [NREG-1:0] busyVec_r;
    logic [NREG-1:0] busyNext_s;
    logic            accept_s;
    logic            rsPend_s;
    logic            rtPend_s;
    logic            stall_s;

    assign accept_s = sb.issue_valid & sb.issue_we & ~sb.hold & ~sb.flush &
                      (sb.issue_rd != ZeroReg);

    // A producer issuing this very cycle with nonzero latency already blocks its readers.
    assign rsPend_s = (cnt_r[sb.rsD] != ZeroCnt) |
                      (accept_s & (sb.issue_rd == sb.rsD) & (sb.issue_lat != ZeroCnt));
    assign rtPend_s = (cnt_r[sb.rtD] != ZeroCnt) |
                      (accept_s & (sb.issue_rd == sb.rtD) & (sb.issue_lat != ZeroCnt));

    assign stall_s = ~sb.flush &
                     ((sb.useRsD & (sb.rsD != ZeroReg) & rsPend_s) |
                      (sb.useRtD & (sb.rtD != ZeroReg) & rtPend_s));

    assign sb.stallD   = stall_s;
    assign sb.busy_vec = busyVec_r;

    // Next countdown per register: flush, then hold, then a new writer, then decrement.
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            if (r == 0) begin
                cntNext_s[r] = ZeroCnt;
            end else if (sb.flush) begin
                cntNext_s[r] = ZeroCnt;
            end else if (sb.hold) begin
                cntNext_s[r] = cnt_r[r];
            end else if (accept_s && (sb.issue_rd == REGW'(r))) begin
                cntNext_s[r] = satLat(sb.issue_lat);
            end else if (cnt_r[r] != ZeroCnt) begin
                cntNext_s[r] = cnt_r[r] - OneCnt;
            end else begin
                cntNext_s[r] = ZeroCnt;
            end
            busyNext_s[r] = (cntNext_s[r] != ZeroCnt);
        end
    end

    // Countdown array and its registered busy view.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int r = 0; r < NREG; r++) begin
                cnt_r[r] <= ZeroCnt;
            end
            busyVec_r <= {NREG{1'b0}};
        end else begin
            for (int r = 0; r < NREG; r++) begin
                cnt_r[r] <= cntNext_s[r];
            end
            busyVec_r <= busyNext_s;
        end
    end

`ifdef HAZARD_SCOREBOARD_PERF_EN
    logic [31:0] stallCycles_r;

    // Counts decode cycles lost to hazards; frozen pipeline cycles are not charged.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stallCycles_r <= 32'd0;
        end else if (stall_s && !sb.hold) begin
            stallCycles_r <= stallCycles_r + 32'd1;
        end else begin
            stallCycles_r <= stallCycles_r;
        end
    end

    assign sb.stall_cycles = stallCycles_r;
`else
    // Without the performance option there is no stall counter.
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench for hazard_scoreboard: a time-stamp reference model predicts each cycle's
// stallD/busy_vec, a monitor compares them against the DUT on the falling edge.
module tb_hazard_scoreboard;
    localparam int NREG   = 32;
    localparam int REGW   = 5;
    localparam int MAXLAT = 8;
    localparam int CNTW   = 4;

    logic clk = 1'b0;
    logic resetn;

    always #5 clk = ~clk;

    hazard_scoreboard_if #(.NREG(NREG), .REGW(REGW), .CNTW(CNTW)) ifc();

    hazard_scoreboard #(.NREG(NREG), .REGW(REGW), .MAXLAT(MAXLAT), .CNTW(CNTW)) dut (
        .clk    (clk),
        .resetn (resetn),
        .sb     (ifc)
    );

    typedef struct {
        bit            stall;
        bit [NREG-1:0] busy;
        bit [31:0]     perf;
        int            idx;
    } exp_t;

    exp_t  expQ[$];
    exp_t  mon;
    int    nTests = 0;
    int    nFail  = 0;
    int    cycNo  = 0;

    // Reference model: a register is pending while the count of unfrozen edges seen so far
    // is below the time stamp at which its newest write becomes forwardable.
    longint    tNow = 0;
    longint    readyAt[NREG];
    bit [31:0] perfCnt;

    function automatic void clearModel();
        for (int r = 0; r < NREG; r++) readyAt[r] = 0;
        perfCnt = 32'd0;
    endfunction

    function automatic bit pendM(input int x, input bit acc, input int rd, input int lat);
        if (x == 0) return 1'b0;
        return (tNow < readyAt[x]) || (acc && rd == x && lat != 0);
    endfunction

    task automatic step(input bit rn, input bit v, input bit we, input int rd, input int lat,
                        input bit h, input bit f, input int rs, input int rt,
                        input bit urs, input bit urt);
        bit            acc;
        bit            es;
        bit [NREG-1:0] eb;
        exp_t          e;
        resetn = rn;
        if (!rn) clearModel();
        ifc.issue_valid = v;
        ifc.issue_we    = we;
        ifc.issue_rd    = REGW'(rd);
        ifc.issue_lat   = CNTW'(lat);
        ifc.hold        = h;
        ifc.flush       = f;
        ifc.rsD         = REGW'(rs);
        ifc.rtD         = REGW'(rt);
        ifc.useRsD      = urs;
        ifc.useRtD      = urt;
        acc = v && we && !h && !f && rd != 0;
        es  = !f && ((urs && pendM(rs, acc, rd, lat)) || (urt && pendM(rt, acc, rd, lat)));
        eb  = '0;
        for (int r = 1; r < NREG; r++) eb[r] = (tNow < readyAt[r]);
        e.stall = es;
        e.busy  = eb;
        e.perf  = perfCnt;
        e.idx   = cycNo;
        expQ.push_back(e);
        @(posedge clk);
        if (!rn) begin
            clearModel();
        end else if (f) begin
            for (int r = 0; r < NREG; r++) readyAt[r] = 0;
            tNow++;
        end else if (!h) begin
            if (acc) readyAt[rd] = tNow + 1 + ((lat > MAXLAT) ? MAXLAT : lat);
            tNow++;
        end
        if (rn && es && !h) perfCnt++;
        cycNo++;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic readRs(input int rs, input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0, rs, 0, 1, 0);
    endtask

    task automatic doReset();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 5, 7, 1, 1);
    endtask

    // Monitor: one prediction per cycle, compared mid-cycle once inputs have settled.
    always @(negedge clk) begin
        if (expQ.size() > 0) begin
            mon = expQ.pop_front();
            nTests++;
            if (ifc.stallD !== mon.stall) begin
                nFail++;
                $display("FAIL stallD @cycle %0d: got %0b, expected %0b",
                         mon.idx, ifc.stallD, mon.stall);
            end
            nTests++;
            if (ifc.busy_vec !== mon.busy) begin
                nFail++;
                $display("FAIL busy_vec @cycle %0d: got %h, expected %h",
                         mon.idx, ifc.busy_vec, mon.busy);
            end
`ifdef HAZARD_SCOREBOARD_PERF_EN
            nTests++;
            if (ifc.stall_cycles !== mon.perf) begin
                nFail++;
                $display("FAIL stall_cycles @cycle %0d: got %0d, expected %0d",
                         mon.idx, ifc.stall_cycles, mon.perf);
            end
`endif
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not finish, got timeout, expected completion");
        $fatal(1, "simulation timeout");
    end

    initial begin
        bit v, h, f, rn;
        clearModel();
        resetn = 1'b0;
        ifc.issue_valid = 1'b0; ifc.issue_we = 1'b0; ifc.issue_rd = '0; ifc.issue_lat = '0;
        ifc.hold = 1'b0; ifc.flush = 1'b0; ifc.rsD = '0; ifc.rtD = '0;
        ifc.useRsD = 1'b0; ifc.useRtD = 1'b0;
        @(posedge clk);
        #1;
        doReset();

        // rd=5 lat=3 blocks a reader for three cycles
        step(1, 1, 1, 5, 3, 0, 0, 0, 0, 0, 0);
        readRs(5, 4);
        // register 0 is never tracked
        step(1, 1, 1, 0, 7, 0, 0, 0, 0, 1, 0);
        readRs(0, 3);
        // hold freezes the countdown
        step(1, 1, 1, 8, 2, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(1, 1, 1, 8, 6, 1, 0, 8, 0, 1, 0);
        readRs(8, 3);
        // WAW: newest writer replaces the count
        step(1, 1, 1, 9, 4, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 9, 0, 1, 0);
        step(1, 1, 1, 9, 1, 0, 0, 9, 0, 1, 0);
        readRs(9, 3);
        // flush beats a simultaneous issue
        step(1, 1, 1, 3, 6, 0, 0, 0, 0, 0, 0);
        step(1, 1, 1, 4, 2, 0, 0, 0, 0, 0, 0);
        step(1, 1, 1, 3, 5, 0, 1, 3, 4, 1, 1);
        step(1, 0, 0, 0, 0, 0, 0, 3, 4, 1, 1);
        idle(2);
        // same-cycle producer, with and without the reader
        step(1, 1, 1, 7, 1, 0, 0, 0, 7, 0, 1);
        step(1, 0, 0, 0, 0, 0, 0, 0, 7, 0, 1);
        idle(2);
        step(1, 1, 1, 7, 1, 0, 0, 0, 7, 0, 0);
        step(1, 1, 1, 7, 0, 0, 0, 0, 7, 0, 1);
        // oversized latency saturates at MAXLAT
        step(1, 1, 1, 10, 15, 0, 0, 0, 0, 0, 0);
        readRs(10, 10);
        // reset in the middle of pending work
        step(1, 1, 1, 11, 6, 0, 0, 0, 0, 0, 0);
        doReset();
        readRs(11, 2);

        for (int i = 0; i < 3000; i++) begin
            rn = ($urandom_range(0, 299) != 0);
            v  = rn && ($urandom_range(0, 2) != 0);
            h  = ($urandom_range(0, 5) == 0);
            f  = ($urandom_range(0, 24) == 0);
            step(rn, v, 1'($urandom_range(0, 7) != 0), int'($urandom_range(0, 7)),
                 int'($urandom_range(0, 15)), h, f, int'($urandom_range(0, 7)),
                 int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        idle(2);

        for (int i = 0; i < 5 && expQ.size() > 0; i++) @(negedge clk);
        #2;
        if (expQ.size() != 0) begin
            nTests++;
            nFail++;
            $display("FAIL drain: got %0d pending predictions, expected 0", expQ.size());
        end
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end
endmodule
